// File: rtl/rv_to_axil_master.sv
// rv_to_axil_master
//
// Turns a ready/valid command stream into AXI4-Lite master transactions and
// returns one ready/valid response per command. Only one transaction is in
// flight at a time.
//
// Ports
//   M00_AXI_aclk, M00_AXI_aresetn     clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o         command handshake
//   cmd_write_i, cmd_addr_i, cmd_data_i   command payload (1=write, 0=read)
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_write_o, rsp_data_o, rsp_resp_o   response payload (data is 0 for writes)
//   M00_AXI_aw*, M00_AXI_w*, M00_AXI_b*   AXI4-Lite write channels
//   M00_AXI_ar*, M00_AXI_r*               AXI4-Lite read channels
//   dbgState                          current FSM state, for observation only
//
// Handshake rule used on every channel: a transfer happens on a rising clock
// edge where valid and ready are both 1. A source holds valid and its payload
// stable until that edge; valid never waits on ready. Every control output is
// a flop, so no input reaches an output combinationally.

module rv_to_axil_master #(
    parameter int          ADDR_W = 4,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic              M00_AXI_aclk,
    input  logic              M00_AXI_aresetn,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [31:0]       cmd_data_i,

    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic              rsp_write_o,
    output logic [31:0]       rsp_data_o,
    output logic [1:0]        rsp_resp_o,

    output logic [ADDR_W-1:0] M00_AXI_awaddr,
    output logic [2:0]        M00_AXI_awprot,
    output logic              M00_AXI_awvalid,
    input  logic              M00_AXI_awready,
    output logic [31:0]       M00_AXI_wdata,
    output logic [3:0]        M00_AXI_wstrb,
    output logic              M00_AXI_wvalid,
    input  logic              M00_AXI_wready,
    input  logic [1:0]        M00_AXI_bresp,
    input  logic              M00_AXI_bvalid,
    output logic              M00_AXI_bready,

    output logic [ADDR_W-1:0] M00_AXI_araddr,
    output logic [2:0]        M00_AXI_arprot,
    output logic              M00_AXI_arvalid,
    input  logic              M00_AXI_arready,
    input  logic [31:0]       M00_AXI_rdata,
    input  logic [1:0]        M00_AXI_rresp,
    input  logic              M00_AXI_rvalid,
    output logic              M00_AXI_rready,

    output logic [2:0]        dbgState
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WRESP   = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } stateT;

    stateT             state,     stateNxt;
    logic              cmdReady,  cmdReadyNxt;
    logic              awValid,   awValidNxt;
    logic              wValid,    wValidNxt;
    logic              bReady,    bReadyNxt;
    logic              arValid,   arValidNxt;
    logic              rReady,    rReadyNxt;
    logic              rspValid,  rspValidNxt;
    logic              rspWrite,  rspWriteNxt;
    logic [31:0]       rspData,   rspDataNxt;
    logic [1:0]        rspResp,   rspRespNxt;
    logic [ADDR_W-1:0] awAddr,    awAddrNxt;
    logic [ADDR_W-1:0] arAddr,    arAddrNxt;
    logic [31:0]       wData,     wDataNxt;

    // A write channel counts as done once its valid is already low or is
    // being accepted on this edge; AW and W finish in any order.
    logic awDone;
    logic wDone;

    always_ff @(posedge M00_AXI_aclk or negedge M00_AXI_aresetn) begin
        if (!M00_AXI_aresetn) begin
            state    <= IDLE;
            cmdReady <= 1'b0;
            awValid  <= 1'b0;
            wValid   <= 1'b0;
            bReady   <= 1'b0;
            arValid  <= 1'b0;
            rReady   <= 1'b0;
            rspValid <= 1'b0;
            rspWrite <= 1'b0;
            rspData  <= '0;
            rspResp  <= '0;
            awAddr   <= '0;
            arAddr   <= '0;
            wData    <= '0;
        end else begin
            state    <= stateNxt;
            cmdReady <= cmdReadyNxt;
            awValid  <= awValidNxt;
            wValid   <= wValidNxt;
            bReady   <= bReadyNxt;
            arValid  <= arValidNxt;
            rReady   <= rReadyNxt;
            rspValid <= rspValidNxt;
            rspWrite <= rspWriteNxt;
            rspData  <= rspDataNxt;
            rspResp  <= rspRespNxt;
            awAddr   <= awAddrNxt;
            arAddr   <= arAddrNxt;
            wData    <= wDataNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        cmdReadyNxt = cmdReady;
        awValidNxt  = awValid;
        wValidNxt   = wValid;
        bReadyNxt   = bReady;
        arValidNxt  = arValid;
        rReadyNxt   = rReady;
        rspValidNxt = rspValid;
        rspWriteNxt = rspWrite;
        rspDataNxt  = rspData;
        rspRespNxt  = rspResp;
        awAddrNxt   = awAddr;
        arAddrNxt   = arAddr;
        wDataNxt    = wData;
        awDone      = !awValid || M00_AXI_awready;
        wDone       = !wValid  || M00_AXI_wready;

        case (state)
            IDLE: begin
                if (cmdReady && cmd_valid_i) begin
                    cmdReadyNxt = 1'b0;
                    if (cmd_write_i) begin
                        stateNxt   = WR;
                        awAddrNxt  = cmd_addr_i;
                        wDataNxt   = cmd_data_i;
                        awValidNxt = 1'b1;
                        wValidNxt  = 1'b1;
                    end else begin
                        stateNxt   = RD_ADDR;
                        arAddrNxt  = cmd_addr_i;
                        arValidNxt = 1'b1;
                    end
                end else begin
                    // Ready rises one cycle after entering IDLE (reset exit or
                    // response handshake).
                    cmdReadyNxt = 1'b1;
                end
            end

            WR: begin
                if (awValid && M00_AXI_awready) awValidNxt = 1'b0;
                if (wValid  && M00_AXI_wready)  wValidNxt  = 1'b0;
                if (awDone && wDone) begin
                    stateNxt  = WRESP;
                    bReadyNxt = 1'b1;
                end
            end

            WRESP: begin
                if (bReady && M00_AXI_bvalid) begin
                    bReadyNxt   = 1'b0;
                    rspRespNxt  = M00_AXI_bresp;
                    rspDataNxt  = '0;
                    rspWriteNxt = 1'b1;
                    rspValidNxt = 1'b1;
                    stateNxt    = RSP;
                end
            end

            RD_ADDR: begin
                if (arValid && M00_AXI_arready) begin
                    arValidNxt = 1'b0;
                    rReadyNxt  = 1'b1;
                    stateNxt   = RD_DATA;
                end
            end

            RD_DATA: begin
                if (rReady && M00_AXI_rvalid) begin
                    rReadyNxt   = 1'b0;
                    rspRespNxt  = M00_AXI_rresp;
                    rspDataNxt  = M00_AXI_rdata;
                    rspWriteNxt = 1'b0;
                    rspValidNxt = 1'b1;
                    stateNxt    = RSP;
                end
            end

            RSP: begin
                if (rsp_ready_i) begin
                    rspValidNxt = 1'b0;
                    stateNxt    = IDLE;
                end
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    assign cmd_ready_o     = cmdReady;
    assign rsp_valid_o     = rspValid;
    assign rsp_write_o     = rspWrite;
    assign rsp_data_o      = rspData;
    assign rsp_resp_o      = rspResp;

    assign M00_AXI_awaddr  = awAddr;
    assign M00_AXI_awprot  = PROT;
    assign M00_AXI_awvalid = awValid;
    assign M00_AXI_wdata   = wData;
    assign M00_AXI_wstrb   = 4'hF;
    assign M00_AXI_wvalid  = wValid;
    assign M00_AXI_bready  = bReady;

    assign M00_AXI_araddr  = arAddr;
    assign M00_AXI_arprot  = PROT;
    assign M00_AXI_arvalid = arValid;
    assign M00_AXI_rready  = rReady;

    assign dbgState        = state;

endmodule

// File: tb/tb_rv_to_axil_master.sv
// tb_rv_to_axil_master
//
// Drives commands into rv_to_axil_master against a small AXI4-Lite memory
// slave (4 words, byte address bits [3:2]) with per-channel ready delays and
// configurable response codes. Expected responses are queued when each
// command is issued; a monitor pops and compares on every response handshake.

module tb_rv_to_axil_master;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rstN;
    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWrite;
    logic [ADDR_W-1:0] cmdAddr;
    logic [31:0]       cmdData;
    logic              rspValid;
    logic              rspReady;
    logic              rspWrite;
    logic [31:0]       rspData;
    logic [1:0]        rspResp;
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;
    logic [2:0]        dbgState;

    rv_to_axil_master #(.ADDR_W(ADDR_W), .PROT(3'b000)) dut (
        .M00_AXI_aclk(clk), .M00_AXI_aresetn(rstN),
        .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_write_i(cmdWrite),
        .cmd_addr_i(cmdAddr), .cmd_data_i(cmdData),
        .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_write_o(rspWrite),
        .rsp_data_o(rspData), .rsp_resp_o(rspResp),
        .M00_AXI_awaddr(awaddr), .M00_AXI_awprot(awprot), .M00_AXI_awvalid(awvalid),
        .M00_AXI_awready(awready), .M00_AXI_wdata(wdata), .M00_AXI_wstrb(wstrb),
        .M00_AXI_wvalid(wvalid), .M00_AXI_wready(wready), .M00_AXI_bresp(bresp),
        .M00_AXI_bvalid(bvalid), .M00_AXI_bready(bready),
        .M00_AXI_araddr(araddr), .M00_AXI_arprot(arprot), .M00_AXI_arvalid(arvalid),
        .M00_AXI_arready(arready), .M00_AXI_rdata(rdata), .M00_AXI_rresp(rresp),
        .M00_AXI_rvalid(rvalid), .M00_AXI_rready(rready),
        .dbgState(dbgState)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [34:0] expQ[$];   // {write, resp[1:0], data[31:0]}
    int checks = 0;
    int errors = 0;
    int rspCount = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    int          awDelay = 0, wDelay = 0, arDelay = 0;
    logic [1:0]  bRespCfg = 2'b00, rRespCfg = 2'b00;
    bit          arBlock = 0;
    int          bHsCount = 0;
    bit          awHave, wHave, arHave;
    int          awCnt, wCnt, arCnt;
    logic        prevBready, prevRready;
    logic [31:0] mem [4];
    logic [ADDR_W-1:0] awAddrS, arAddrS;
    logic [31:0] wDataS;

    // Runs on the falling edge: a ready raised here is seen at the next
    // rising edge, and a ready that is still high on the following falling
    // edge means that rising edge completed the handshake.
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rresp = 0; rdata = 0;
        awHave = 0; wHave = 0; arHave = 0; awCnt = 0; wCnt = 0; arCnt = 0;
        prevBready = 0; prevRready = 0; awAddrS = 0; arAddrS = 0; wDataS = 0;
        for (int i = 0; i < 4; i++) mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            if (!rstN) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                awHave = 0; wHave = 0; arHave = 0; awCnt = 0; wCnt = 0; arCnt = 0;
            end else begin
                if (awready) begin
                    chk("awvalid_drop", {31'b0, awvalid}, 32'd0);
                    chk("wvalid_hold", {31'b0, wvalid}, {31'b0, (!wHave && !wready)});
                    awready = 0; awHave = 1; awCnt = 0;
                end else if (awvalid && !awHave) begin
                    if (awCnt >= awDelay) begin awready = 1; awAddrS = awaddr; end
                    else awCnt++;
                end
                if (wready) begin
                    chk("wvalid_drop", {31'b0, wvalid}, 32'd0);
                    chk("awvalid_hold", {31'b0, awvalid}, {31'b0, (!awHave)});
                    wready = 0; wHave = 1; wCnt = 0;
                end else if (wvalid && !wHave) begin
                    if (wCnt >= wDelay) begin wready = 1; wDataS = wdata; end
                    else wCnt++;
                end
                if (bvalid) begin
                    if (prevBready) begin bvalid = 0; bHsCount++; awHave = 0; wHave = 0; end
                end else if (awHave && wHave) begin
                    mem[awAddrS[3:2]] = wDataS;
                    bresp = bRespCfg;
                    bvalid = 1;
                end
                if (arready) begin
                    chk("arvalid_drop", {31'b0, arvalid}, 32'd0);
                    arready = 0; arHave = 1; arCnt = 0;
                end else if (arvalid && !arHave && !arBlock) begin
                    if (arCnt >= arDelay) begin arready = 1; arAddrS = araddr; end
                    else arCnt++;
                end
                if (rvalid) begin
                    if (prevRready) begin rvalid = 0; arHave = 0; end
                end else if (arHave) begin
                    rdata = mem[arAddrS[3:2]];
                    rresp = rRespCfg;
                    rvalid = 1;
                end
            end
            prevBready = bready;
            prevRready = rready;
        end
    end

    // ---------------- response monitor ----------------
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rstN && rspValid && rspReady) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got write=%0b resp=%0h data=%h, expected no response",
                             rspWrite, rspResp, rspData);
                end else begin
                    e = expQ.pop_front();
                    chk("rsp_write", {31'b0, rspWrite}, {31'b0, e[34]});
                    chk("rsp_resp", {30'b0, rspResp}, {30'b0, e[33:32]});
                    chk("rsp_data", rspData, e[31:0]);
                    rspCount++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge; returns on the falling edge after the
    // accepting rising edge with cmdValid still high.
    task automatic sendCmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                           input bit expRsp, input logic [1:0] expResp, input logic [31:0] expData);
        int n;
        if (expRsp) expQ.push_back({wr, expResp, expData});
        cmdValid = 1; cmdWrite = wr; cmdAddr = a; cmdData = d;
        n = 0;
        while (!cmdReady && n < 200) begin @(negedge clk); n++; end
        if (!cmdReady) begin
            checks++; errors++;
            $display("FAIL cmd_accept_timeout: got cmd_ready=0, expected 1 within 200 cycles");
        end
        @(negedge clk);
    endtask

    task automatic clearCmd();
        cmdValid = 0; cmdWrite = 0; cmdAddr = 0; cmdData = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (expQ.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d responses outstanding, expected 0", expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_cmd_ready"}, {31'b0, cmdReady}, 0);
        chk({tag, "_rsp_valid"}, {31'b0, rspValid}, 0);
        chk({tag, "_rsp_write"}, {31'b0, rspWrite}, 0);
        chk({tag, "_rsp_data"}, rspData, 0);
        chk({tag, "_rsp_resp"}, {30'b0, rspResp}, 0);
        chk({tag, "_valids"}, {27'b0, awvalid, wvalid, bready, arvalid, rready}, 0);
        chk({tag, "_addrs"}, {24'b0, awaddr, araddr}, 0);
        chk({tag, "_wdata"}, wdata, 0);
        chk({tag, "_consts"}, {25'b0, awprot, wstrb}, 32'h0000000F);
    endtask

    task automatic latency(input string name);
        int n;
        n = 0;
        while (!rspValid && n < 50) begin @(negedge clk); n++; end
        chk(name, n, 2);
    endtask

    // ---------------- directed sequence ----------------
    logic [ADDR_W-1:0] b2bAddr [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    logic [31:0]       b2bData [5] = '{32'h0000_0001, 32'hA5A5_5A5A, 32'hFFFF_FFFF,
                                       32'h8000_0000, 32'h0BAD_F00D};
    int                ordAw   [3] = '{0, 3, 0};
    int                ordW    [3] = '{3, 0, 0};
    logic [31:0]       ordData [3] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};

    initial begin
        int bHs0;
        int n;
        rstN = 0; rspReady = 1;
        clearCmd();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        chk("reset_state", {29'b0, dbgState}, 0);
        rstN = 1;
        chk("rel_cmd_ready_lo", {31'b0, cmdReady}, 0);
        @(negedge clk);
        chk("rel_cmd_ready_hi", {31'b0, cmdReady}, 1);

        // Write then read back through the memory slave, zero-wait latency.
        sendCmd(1, 4'h0, 32'hDEAD_BEEF, 1, 2'b00, 32'h0);
        clearCmd();
        latency("wr_latency");
        drain();
        sendCmd(0, 4'h0, 32'h0, 1, 2'b00, 32'hDEAD_BEEF);
        clearCmd();
        latency("rd_latency");
        drain();

        // AW before W, W before AW, then both together.
        for (int i = 0; i < 3; i++) begin
            awDelay = ordAw[i]; wDelay = ordW[i];
            bHs0 = bHsCount;
            sendCmd(1, 4'h4, ordData[i], 1, 2'b00, 32'h0);
            clearCmd();
            drain();
            chk("bready_hs_count", bHsCount - bHs0, 1);
        end
        awDelay = 0; wDelay = 0;
        sendCmd(0, 4'h4, 32'h0, 1, 2'b00, 32'h3333_0003);
        clearCmd();
        drain();

        // Error responses passed through unchanged.
        bRespCfg = 2'b10;
        sendCmd(1, 4'h8, 32'hAAAA_5555, 1, 2'b10, 32'h0);
        clearCmd();
        drain();
        bRespCfg = 2'b00; rRespCfg = 2'b11;
        sendCmd(0, 4'h8, 32'h0, 1, 2'b11, 32'hAAAA_5555);
        clearCmd();
        drain();
        rRespCfg = 2'b00;

        // Response back-pressure for 20 cycles.
        sendCmd(1, 4'hC, 32'h1234_5678, 1, 2'b00, 32'h0);
        clearCmd();
        drain();
        rspReady = 0;
        sendCmd(0, 4'hC, 32'h0, 1, 2'b00, 32'h1234_5678);
        clearCmd();
        n = 0;
        while (!rspValid && n < 50) begin @(negedge clk); n++; end
        chk("hold_rsp_seen", {31'b0, rspValid}, 1);
        cmdValid = 1; cmdWrite = 1; cmdAddr = 4'h0; cmdData = 32'h5555_AAAA;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", {31'b0, rspValid}, 1);
            chk("hold_rsp_data", rspData, 32'h1234_5678);
            chk("hold_cmd_ready", {31'b0, cmdReady}, 0);
            chk("hold_axi_valid", {29'b0, awvalid, wvalid, arvalid}, 0);
        end
        clearCmd();
        rspReady = 1;
        drain();

        // Reset while a read address is stuck waiting for arready.
        arBlock = 1;
        sendCmd(0, 4'h4, 32'h0, 0, 2'b00, 32'h0);
        clearCmd();
        chk("stuck_arvalid", {31'b0, arvalid}, 1);
        rstN = 0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        @(negedge clk);
        arBlock = 0;
        rstN = 1;
        chk("rel2_cmd_ready_lo", {31'b0, cmdReady}, 0);
        @(negedge clk);
        chk("rel2_cmd_ready_hi", {31'b0, cmdReady}, 1);
        sendCmd(1, 4'h0, 32'hCAFE_F00D, 1, 2'b00, 32'h0);
        clearCmd();
        drain();
        sendCmd(0, 4'h0, 32'h0, 1, 2'b00, 32'hCAFE_F00D);
        clearCmd();
        drain();

        // Ten back-to-back alternating commands with cmdValid held high.
        n = rspCount;
        for (int i = 0; i < 5; i++) begin
            sendCmd(1, b2bAddr[i], b2bData[i], 1, 2'b00, 32'h0);
            sendCmd(0, b2bAddr[i], 32'h0, 1, 2'b00, b2bData[i]);
        end
        clearCmd();
        drain();
        chk("b2b_rsp_count", rspCount - n, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        errors++;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/rv_to_axil_master.md
Name: rv_to_axil_master

Overview:
Bridges a ready/valid command/response interface onto an AXI4-Lite master port. It is the inverse of the AXI-Lite-to-ready/valid slave bridge. User logic pushes write or read commands and receives one response per command. Used to drive AXI-Lite register slaves, including our own ready/valid slave bridge, from streaming logic. One transaction in flight at a time.

Parameters:
ADDR_W, 4, width of cmd_addr_i, M00_AXI_awaddr and M00_AXI_araddr
PROT, 3'b000, constant driven on awprot/arprot

Ports:
M00_AXI_aclk  in  1  clock
M00_AXI_aresetn  in  1  reset, asynchronous, active-low
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_write_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  byte address
cmd_data_i  in  32  write data (ignored for reads)
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_write_o  out  1  echo of cmd_write_i for this response
rsp_data_o  out  32  read data; 0 for writes
rsp_resp_o  out  2  bresp/rresp as received
M00_AXI_awaddr  out  ADDR_W  write address
M00_AXI_awprot  out  3  =PROT
M00_AXI_awvalid  out  1  write address valid
M00_AXI_awready  in  1  write address ready
M00_AXI_wdata  out  32  write data
M00_AXI_wstrb  out  4  constant 4'hF
M00_AXI_wvalid  out  1  write data valid
M00_AXI_wready  in  1  write data ready
M00_AXI_bresp  in  2  write response
M00_AXI_bvalid  in  1  write response valid
M00_AXI_bready  out  1  write response ready
M00_AXI_araddr  out  ADDR_W  read address
M00_AXI_arprot  out  3  =PROT
M00_AXI_arvalid  out  1  read address valid
M00_AXI_arready  in  1  read address ready
M00_AXI_rdata  in  32  read data
M00_AXI_rresp  in  2  read response
M00_AXI_rvalid  in  1  read data valid
M00_AXI_rready  out  1  read data ready

Behaviour:
- Reset (aresetn=0, asynchronous): state IDLE. All valid/ready outputs 0, including cmd_ready_o. rsp_data_o=0, rsp_resp_o=0, rsp_write_o=0, awaddr/araddr/wdata=0. Reset mid-transaction drops the transaction with no response. The AXI slave shares the reset.
- All control outputs are registered; no combinational path from any input to any output.
- FSM states: IDLE, WR (AW/W phase), WRESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready_o=1. On cmd_valid_i&cmd_ready_o, latch addr/data/write.
  - Write: next state WR; awvalid=wvalid=1 in the next cycle.
  - Read: next state RD_ADDR; arvalid=1 in the next cycle.
  - cmd_ready_o drops to 0 the cycle after acceptance.
- WR: awvalid and wvalid are tracked independently. Each deasserts the cycle after its own handshake. Either order or same-cycle completion is legal. When both are done, next state WRESP with bready=1.
- WRESP: on bvalid&bready, capture bresp, set rsp_data_o=0 and rsp_write_o=1, then go to RSP. bready=0 from the next cycle.
- RD_ADDR: hold arvalid and araddr stable until arready. Then go to RD_DATA with rready=1.
- RD_DATA: on rvalid&rready, capture rdata/rresp, set rsp_write_o=0, go to RSP. rready=0 next cycle.
- RSP: rsp_valid_o=1. Data held stable while rsp_ready_i=0, indefinitely. On handshake, go to IDLE; cmd_ready_o=1 in the following cycle.
- AXI outputs stay stable while their valid is high and unacknowledged.
- Latency with a zero-wait slave and rsp_ready_i=1:
  - Write: cmd accept at N; aw/w handshake N+1; bready N+2; bvalid accepted at ≥N+2; rsp_valid ≥N+3.
  - Read: same timing with ar/r in place of aw/w.
  - Next cmd_ready_o two cycles after the rsp handshake's preceding state transition (RSP→IDLE→ready).
- Response codes are passed through unmodified (OKAY, EXOKAY, SLVERR, DECERR). The block never generates errors.
- cmd_valid_i while cmd_ready_o=0 has no effect.

Test Plan:
- Chain with the AXI-Lite-to-ready/valid slave and rvReg on port A. Write addr 0 data 0xdeadbeef -> rsp_write_o=1, rsp_resp_o=0. Then read addr 0 -> rsp_write_o=0, rsp_data_o=0xdeadbeef, rsp_resp_o=0.
- Stub slave asserts awready 3 cycles before wready, then vice versa, then same cycle -> each of awvalid/wvalid drops one cycle after its own handshake; exactly one bready handshake; one response.
- Stub slave returns bresp=2'b10 and rresp=2'b11 -> rsp_resp_o equals 2'b10 and 2'b11; rsp_data_o=0 for the write.
- Hold rsp_ready_i=0 for 20 cycles after a read of 0x12345678 -> rsp_valid_o stays 1, data stable, cmd_ready_o stays 0, no new AXI valid asserted.
- Assert aresetn=0 while arvalid=1 and arready held 0 -> all outputs 0 immediately. After release: cmd_ready_o=1 one cycle later, no response emitted, and a new write completes normally.
- Ten back-to-back alternating write/read commands, cmd_valid_i held high -> ten responses in order, each read returns the preceding written value.
